// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: 1-cycle copy of ID fields with stall hold and flush bubble.
// Optional IDEX_STATS_EN adds saturating bubble/stall/issue counters.
module id_ex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               ID_Valid,
  input  logic [DATA_W-1:0]  ID_PCPlus4,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [REG_W-1:0]   ID_Rs,
  input  logic [REG_W-1:0]   ID_Rt,
  input  logic [REG_W-1:0]   ID_Rd,
  input  logic [REG_W-1:0]   ID_Shamt,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemToReg,
  input  logic               ID_ALUSrc,
  input  logic [1:0]         ID_RegDst,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  output logic               EX_Valid,
  output logic [DATA_W-1:0]  EX_PCPlus4,
  output logic [DATA_W-1:0]  EX_ReadData1,
  output logic [DATA_W-1:0]  EX_ReadData2,
  output logic [DATA_W-1:0]  EX_Imm,
  output logic [REG_W-1:0]   EX_Rs,
  output logic [REG_W-1:0]   EX_Rt,
  output logic [REG_W-1:0]   EX_Rd,
  output logic [REG_W-1:0]   EX_Shamt,
  output logic               EX_RegWrite,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_MemToReg,
  output logic               EX_ALUSrc,
  output logic [1:0]         EX_RegDst,
  output logic [ALUOP_W-1:0] EX_ALUOp
`ifdef IDEX_STATS_EN
  ,
  output logic [31:0]        StatBubbles,
  output logic [31:0]        StatStalls,
  output logic [31:0]        StatIssued
`endif
);

  logic               r_valid;
  logic [DATA_W-1:0]  r_pc4, r_rd1, r_rd2, r_imm;
  logic [REG_W-1:0]   r_rs, r_rt, r_rd, r_shamt;
  logic               r_regwr, r_memrd, r_memwr, r_m2r, r_alusrc;
  logic [1:0]         r_regdst;
  logic [ALUOP_W-1:0] r_aluop;

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      r_valid  <= 1'b0;
      r_pc4    <= '0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_imm    <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_shamt  <= '0;
      r_regwr  <= 1'b0;
      r_memrd  <= 1'b0;
      r_memwr  <= 1'b0;
      r_m2r    <= 1'b0;
      r_alusrc <= 1'b0;
      r_regdst <= '0;
      r_aluop  <= '0;
    end else if (!Stall) begin
      r_pc4   <= ID_PCPlus4;
      r_rd1   <= ID_ReadData1;
      r_rd2   <= ID_ReadData2;
      r_imm   <= ID_Imm;
      r_rs    <= ID_Rs;
      r_rt    <= ID_Rt;
      r_rd    <= ID_Rd;
      r_shamt <= ID_Shamt;
      // An invalid slot still carries data but can never cause side effects
      r_valid  <= ID_Valid;
      r_regwr  <= ID_Valid & ID_RegWrite;
      r_memrd  <= ID_Valid & ID_MemRead;
      r_memwr  <= ID_Valid & ID_MemWrite;
      r_m2r    <= ID_Valid & ID_MemToReg;
      r_alusrc <= ID_Valid & ID_ALUSrc;
      r_regdst <= ID_Valid ? ID_RegDst : 2'b00;
      r_aluop  <= ID_Valid ? ID_ALUOp : '0;
    end
  end

  assign EX_Valid     = r_valid;
  assign EX_PCPlus4   = r_pc4;
  assign EX_ReadData1 = r_rd1;
  assign EX_ReadData2 = r_rd2;
  assign EX_Imm       = r_imm;
  assign EX_Rs        = r_rs;
  assign EX_Rt        = r_rt;
  assign EX_Rd        = r_rd;
  assign EX_Shamt     = r_shamt;
  assign EX_RegWrite  = r_regwr;
  assign EX_MemRead   = r_memrd;
  assign EX_MemWrite  = r_memwr;
  assign EX_MemToReg  = r_m2r;
  assign EX_ALUSrc    = r_alusrc;
  assign EX_RegDst    = r_regdst;
  assign EX_ALUOp     = r_aluop;

`ifdef IDEX_STATS_EN
  logic [31:0] r_bub, r_stl, r_iss;
  logic        w_bub_inc, w_stl_inc, w_iss_inc;

  assign w_bub_inc = Flush | (!Stall & !ID_Valid);
  assign w_stl_inc = !Flush & Stall;
  assign w_iss_inc = !Flush & !Stall & ID_Valid;

  // Counters saturate rather than wrap
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bub <= '0;
      r_stl <= '0;
      r_iss <= '0;
    end else begin
      if (w_bub_inc && r_bub != '1) r_bub <= r_bub + 32'd1;
      if (w_stl_inc && r_stl != '1) r_stl <= r_stl + 32'd1;
      if (w_iss_inc && r_iss != '1) r_iss <= r_iss + 32'd1;
    end
  end

  assign StatBubbles = r_bub;
  assign StatStalls  = r_stl;
  assign StatIssued  = r_iss;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for id_ex_stage_reg.
// Stats checks are compiled in when IDEX_STATS_EN is defined.
module tb_id_ex_stage_reg;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, ID_Valid;
  logic [31:0] ID_PCPlus4, ID_ReadData1, ID_ReadData2, ID_Imm;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd, ID_Shamt;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc;
  logic [1:0]  ID_RegDst;
  logic [3:0]  ID_ALUOp;
  logic        EX_Valid;
  logic [31:0] EX_PCPlus4, EX_ReadData1, EX_ReadData2, EX_Imm;
  logic [4:0]  EX_Rs, EX_Rt, EX_Rd, EX_Shamt;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc;
  logic [1:0]  EX_RegDst;
  logic [3:0]  EX_ALUOp;
`ifdef IDEX_STATS_EN
  logic [31:0] StatBubbles, StatStalls, StatIssued;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  id_ex_stage_reg dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .ID_Valid(ID_Valid), .ID_PCPlus4(ID_PCPlus4),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_Shamt(ID_Shamt), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc),
    .ID_RegDst(ID_RegDst), .ID_ALUOp(ID_ALUOp),
    .EX_Valid(EX_Valid), .EX_PCPlus4(EX_PCPlus4),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_Imm(EX_Imm), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_Shamt(EX_Shamt), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemToReg(EX_MemToReg), .EX_ALUSrc(EX_ALUSrc),
    .EX_RegDst(EX_RegDst), .EX_ALUOp(EX_ALUOp)
`ifdef IDEX_STATS_EN
    ,
    .StatBubbles(StatBubbles), .StatStalls(StatStalls),
    .StatIssued(StatIssued)
`endif
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_id;
    ID_Valid = 0; ID_PCPlus4 = 0; ID_ReadData1 = 0; ID_ReadData2 = 0;
    ID_Imm = 0; ID_Rs = 0; ID_Rt = 0; ID_Rd = 0; ID_Shamt = 0;
    ID_RegWrite = 0; ID_MemRead = 0; ID_MemWrite = 0;
    ID_MemToReg = 0; ID_ALUSrc = 0; ID_RegDst = 0; ID_ALUOp = 0;
  endtask

  task automatic test_reset;
    logic [31:0] dor;
    ID_Valid = 1; ID_PCPlus4 = '1; ID_ReadData1 = '1; ID_ReadData2 = '1;
    ID_Imm = '1; ID_Rs = '1; ID_Rt = '1; ID_Rd = '1; ID_Shamt = '1;
    ID_RegWrite = 1; ID_MemRead = 1; ID_MemWrite = 1;
    ID_MemToReg = 1; ID_ALUSrc = 1; ID_RegDst = '1; ID_ALUOp = '1;
    Reset = 1; Stall = 0; Flush = 0;
    tick(); tick();
    n_cmp++;
    if (EX_Valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got %b want 0", EX_Valid);
    end
    dor = EX_PCPlus4 | EX_ReadData1 | EX_ReadData2 | EX_Imm;
    n_cmp++;
    if (dor !== 32'h0) begin
      n_err++; $display("FAIL reset_data got %h want 0", dor);
    end
    n_cmp++;
    if ({EX_Rs, EX_Rt, EX_Rd, EX_Shamt} !== 20'h0) begin
      n_err++; $display("FAIL reset_regs got %h want 0",
                        {EX_Rs, EX_Rt, EX_Rd, EX_Shamt});
    end
    n_cmp++;
    if ({EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc,
         EX_RegDst, EX_ALUOp} !== 11'h0) begin
      n_err++; $display("FAIL reset_ctrl got nonzero control");
    end
    Reset = 0;
    clear_id();
  endtask

  task automatic test_load;
    clear_id();
    ID_Imm = 32'hFFFF8000; ID_ReadData1 = 32'h12345678;
    ID_RegWrite = 1; ID_ALUOp = 4'h3; ID_Valid = 1;
    tick();
    n_cmp++;
    if (EX_Imm !== 32'hFFFF8000) begin
      n_err++; $display("FAIL load_imm got %h want ffff8000", EX_Imm);
    end
    n_cmp++;
    if (EX_ReadData1 !== 32'h12345678) begin
      n_err++; $display("FAIL load_rd1 got %h want 12345678", EX_ReadData1);
    end
    n_cmp++;
    if ({EX_Valid, EX_RegWrite, EX_ALUOp} !== 6'b11_0011) begin
      n_err++; $display("FAIL load_ctrl got %b want 110011",
                        {EX_Valid, EX_RegWrite, EX_ALUOp});
    end
  endtask

  task automatic test_stall;
    Stall = 1;
    ID_Imm = 32'h00000005;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (EX_Imm !== 32'hFFFF8000 || EX_Valid !== 1'b1 ||
          EX_RegWrite !== 1'b1) begin
        n_err++; $display("FAIL stall_hold%0d got imm=%h v=%b want ffff8000 v=1",
                          i, EX_Imm, EX_Valid);
      end
    end
    Stall = 0;
    tick();
    n_cmp++;
    if (EX_Imm !== 32'h00000005) begin
      n_err++; $display("FAIL stall_release got %h want 00000005", EX_Imm);
    end
  endtask

  task automatic test_stall_flush;
    clear_id();
    ID_Valid = 1; ID_MemWrite = 1; ID_Imm = 32'hDEADBEEF;
    Stall = 1; Flush = 1;
    tick();
    n_cmp++;
    if ({EX_MemWrite, EX_Valid} !== 2'b00 || EX_Imm !== 32'h0) begin
      n_err++; $display("FAIL stall_flush got mw=%b v=%b imm=%h want 0 0 0",
                        EX_MemWrite, EX_Valid, EX_Imm);
    end
    Stall = 0;
    ID_Imm = 'x; ID_ReadData1 = 'x; ID_Rd = 'x; ID_ALUOp = 'x;
    tick();
    n_cmp++;
    if (EX_Imm !== 32'h0 || EX_ReadData1 !== 32'h0 ||
        EX_Rd !== 5'h0 || EX_ALUOp !== 4'h0) begin
      n_err++; $display("FAIL flush_x got imm=%h rd1=%h want 0",
                        EX_Imm, EX_ReadData1);
    end
    Flush = 0;
    clear_id();
  endtask

  task automatic test_invalid_load;
    clear_id();
    ID_Valid = 0; ID_RegWrite = 1; ID_Rd = 5'd9;
    ID_MemWrite = 1; ID_ALUOp = 4'hA; ID_ReadData2 = 32'hCAFE0001;
    tick();
    n_cmp++;
    if ({EX_RegWrite, EX_MemWrite, EX_Valid} !== 3'b000 ||
        EX_ALUOp !== 4'h0) begin
      n_err++; $display("FAIL inv_ctrl got rw=%b mw=%b v=%b op=%h want 0",
                        EX_RegWrite, EX_MemWrite, EX_Valid, EX_ALUOp);
    end
    n_cmp++;
    if (EX_Rd !== 5'd9 || EX_ReadData2 !== 32'hCAFE0001) begin
      n_err++; $display("FAIL inv_data got rd=%0d rd2=%h want 9 cafe0001",
                        EX_Rd, EX_ReadData2);
    end
  endtask

  task automatic test_back_to_back;
    clear_id();
    ID_Valid = 1; ID_PCPlus4 = 32'h00400004; ID_Rs = 5'd1; ID_Rt = 5'd2;
    ID_MemRead = 1; ID_MemToReg = 1; ID_ALUSrc = 1; ID_RegDst = 2'd0;
    tick();
    ID_PCPlus4 = 32'h00400008; ID_Rs = 5'd3; ID_Rt = 5'd4; ID_Shamt = 5'd7;
    ID_MemRead = 0; ID_MemToReg = 0; ID_ALUSrc = 0; ID_RegDst = 2'd2;
    n_cmp++;
    if (EX_PCPlus4 !== 32'h00400004 || {EX_Rs, EX_Rt} !== {5'd1, 5'd2} ||
        {EX_MemRead, EX_MemToReg, EX_ALUSrc, EX_RegDst} !== 5'b11100) begin
      n_err++; $display("FAIL b2b_first got pc=%h want 00400004", EX_PCPlus4);
    end
    tick();
    n_cmp++;
    if (EX_PCPlus4 !== 32'h00400008 || {EX_Rs, EX_Rt} !== {5'd3, 5'd4} ||
        EX_Shamt !== 5'd7 ||
        {EX_MemRead, EX_MemToReg, EX_ALUSrc, EX_RegDst} !== 5'b00010) begin
      n_err++; $display("FAIL b2b_second got pc=%h dst=%0d want 00400008 2",
                        EX_PCPlus4, EX_RegDst);
    end
  endtask

  task automatic test_reset_mid_stall;
    clear_id();
    ID_Valid = 1; ID_RegWrite = 1; ID_Imm = 32'h11;
    tick();
    Stall = 1; Reset = 1;
    tick();
    n_cmp++;
    if ({EX_Valid, EX_RegWrite} !== 2'b00 || EX_Imm !== 32'h0) begin
      n_err++; $display("FAIL reset_stall got v=%b rw=%b imm=%h want 0",
                        EX_Valid, EX_RegWrite, EX_Imm);
    end
    Stall = 0; Reset = 0;
  endtask

`ifdef IDEX_STATS_EN
  task automatic test_stats;
    clear_id();
    Reset = 1; tick(); Reset = 0;
    n_cmp++;
    if ({StatIssued, StatBubbles, StatStalls} !== 96'h0) begin
      n_err++; $display("FAIL stats_init got i=%0d b=%0d s=%0d want 0",
                        StatIssued, StatBubbles, StatStalls);
    end
    ID_Valid = 1; tick(); tick();
    ID_Valid = 0; tick();
    ID_Valid = 1; tick();
    Stall = 1; tick(); tick(); Stall = 0;
    Flush = 1; tick(); Flush = 0;
    n_cmp++;
    if (StatIssued !== 32'd3 || StatBubbles !== 32'd2 ||
        StatStalls !== 32'd2) begin
      n_err++; $display("FAIL stats_count got i=%0d b=%0d s=%0d want 3 2 2",
                        StatIssued, StatBubbles, StatStalls);
    end
    Reset = 1; tick(); Reset = 0;
    n_cmp++;
    if ({StatIssued, StatBubbles, StatStalls} !== 96'h0) begin
      n_err++; $display("FAIL stats_reset got i=%0d b=%0d s=%0d want 0",
                        StatIssued, StatBubbles, StatStalls);
    end
  endtask
`endif

  initial begin
    Reset = 1; Stall = 0; Flush = 0;
    clear_id();
    @(negedge Clk);
    test_reset();
    test_load();
    test_stall();
    test_stall_flush();
    test_invalid_load();
    test_back_to_back();
    test_reset_mid_stall();
`ifdef IDEX_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
